// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait with timeout.
// Optional stall-cycle counter is compiled only when PIPE_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_flush,
  output logic        memwb_bubble,
  output logic        pc_sel_branch,
  output logic [1:0]  state,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, LDUSE = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       hz, hz_live, tk, mw, timeout;

  assign hz = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign tk = mem_branch & mem_zero;
  assign mw = (mem_memread | mem_memwrite) & ~dmem_ready;
  // The EX slot after a flush or load-use bubble cannot hold a load that still conflicts.
  assign hz_live = hz & ((state_q == RUN) | (state_q == MEMWAIT));
  assign timeout = (state_q == MEMWAIT) & mw & (({1'b0, wait_cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (mw)
      state_d = timeout ? RUN : MEMWAIT;
    else if (tk)
      state_d = FLUSH;
    else if (hz_live)
      state_d = LDUSE;
  end

  assign wait_cnt_d = ((state_q == MEMWAIT) && (state_d == MEMWAIT)) ? wait_cnt_q + 8'd1 : 8'd0;
  assign mem_err_d  = mem_err_q | timeout;

  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    exmem_we      = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    pc_sel_branch = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mw) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (tk) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exmem_flush   = 1'b1;
    end else if (hz_live) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef PIPE_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (!pc_we)
      stall_cnt_q <= sat_inc16(stall_cnt_q);
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table from RUN plus multi-cycle stall, wait, timeout and reset sequences.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        ex_memread = 1'b0, mem_branch = 1'b0, mem_zero = 1'b0;
  logic        mem_memread = 1'b0, mem_memwrite = 1'b0, dmem_ready = 1'b0;
  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_sel_branch;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [8:0]  outs;

  int total = 0;
  int bad = 0;

  localparam logic [8:0] O_RUN   = 9'b1111_0000_0;
  localparam logic [8:0] O_HZ    = 9'b0011_0100_0;
  localparam logic [8:0] O_TK    = 9'b1111_1110_1;
  localparam logic [8:0] O_MW    = 9'b0000_0001_0;
  localparam logic [8:0] O_RST   = 9'b0000_1111_0;
`ifdef PIPE_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd3;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .pc_sel_branch(pc_sel_branch), .state(state),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble,
                 exmem_flush, memwb_bubble, pc_sel_branch};

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, zr, mrd, mwr, rdy;
    logic [8:0] exp_outs;
    logic [1:0] exp_nxt;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                       input logic [4:0] rd, input logic br, input logic zr,
                       input logic mrd, input logic mwr, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_memread = mr; ex_rd = rd;
    mem_branch = br; mem_zero = zr; mem_memread = mrd; mem_memwrite = mwr; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0};
    vt[1]  = '{5'd3, 5'd7, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_HZ,  2'd1};
    vt[2]  = '{5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0};
    vt[3]  = '{5'd9, 5'd2, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0};
    vt[4]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_TK,  2'd2};
    vt[5]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0};
    vt[6]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_MW,  2'd3};
    vt[7]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN, 2'd0};
    vt[8]  = '{5'd4, 5'd1, 5'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_MW,  2'd3};
    vt[9]  = '{5'd6, 5'd6, 5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_TK,  2'd2};
    vt[10] = '{5'd1, 5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_HZ,  2'd1};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_outs", outs, O_RST);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vt[i].rs1, vt[i].rs2, vt[i].mr, vt[i].rd, vt[i].br, vt[i].zr,
            vt[i].mrd, vt[i].mwr, vt[i].rdy);
      #1;
      chk($sformatf("vec%0d_state", i), state, 2'd0);
      chk($sformatf("vec%0d_outs", i), outs, vt[i].exp_outs);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_next", i), state, vt[i].exp_nxt);
      idle();
      @(posedge clk); #1;
      chk($sformatf("vec%0d_back", i), state, 2'd0);
    end

    // Load-use: one stall cycle, then LDUSE with hazard still visible is ignored.
    @(negedge clk);
    drive(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_stall", outs, O_HZ);
    @(posedge clk); #1;
    chk("lu_state", state, 2'd1);
    chk("lu_run_outs", outs, O_RUN);
    idle();
    @(posedge clk); #1 chk("lu_back", state, 2'd0);

    // Branch and hazard together: flush wins, then FLUSH ignores the hazard.
    @(negedge clk);
    drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("bh_outs", outs, O_TK);
    @(posedge clk); #1;
    mem_branch = 1'b0;
    #1;
    chk("bh_state", state, 2'd2);
    chk("bh_flush_outs", outs, O_RUN);
    idle();
    @(posedge clk); #1 chk("bh_back", state, 2'd0);

    // Memory wait three cycles, ready on the fourth.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw%0d_outs", c), outs, O_MW);
      chk($sformatf("mw%0d_state", c), state, (c == 0) ? 2'd0 : 2'd3);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_state", state, 2'd3);
    chk("mw_ready_outs", outs, O_RUN);
    @(posedge clk); #1;
    idle();
    chk("mw_done_state", state, 2'd0);
    chk("mw_stall_cnt", stall_cnt, EXP_STALL);

    // Timeout after four MEMWAIT cycles, error sticky afterwards.
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk($sformatf("to%0d_state", e), state, 2'd3);
      chk($sformatf("to%0d_err", e), mem_err, 1'b0);
    end
    @(posedge clk); #1;
    chk("to_state_run", state, 2'd0);
    chk("to_err_set", mem_err, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", mem_err, 1'b1);
    chk("to_state_idle", state, 2'd0);

    // Reset asserted in the middle of a MEMWAIT cycle.
    @(negedge clk);
    mem_memread = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rm_in_wait", state, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_state", state, 2'd0);
    chk("rm_outs", outs, O_RST);
    chk("rm_err_clr", mem_err, 1'b0);
    chk("rm_stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rm_after_state", state, 2'd0);
    chk("rm_after_outs", outs, O_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MEMWAIT cycles before error (1..255).
REQ-002 SHALL have ports:
  clk  in  1  pipeline clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  id_rs1, id_rs2  in  5  source regs of instruction in ID
  ex_memread  in  1  instruction in EX is a load
  ex_rd  in  5  destination reg of instruction in EX
  mem_branch, mem_zero  in  1  branch flag and ALU zero in MEM
  mem_memread, mem_memwrite  in  1  data-memory access in MEM
  dmem_ready  in  1  data memory completes access this cycle
  pc_we, ifid_we, idex_we, exmem_we  out  1  stage register load enables
  ifid_flush, idex_bubble, exmem_flush, memwb_bubble  out  1  zero control/valid bits of that stage register
  pc_sel_branch  out  1  PC takes MEM branch target
  state  out  2  FSM state encoding
  mem_err  out  1  sticky data-memory timeout
  stall_cnt  out  16  stall-cycle counter (macro-gated)

Function
REQ-003 SHALL implement FSM: RUN=0, LDUSE=1, FLUSH=2, MEMWAIT=3.
REQ-004 SHALL define: hz = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); tk = mem_branch & mem_zero; mw = (mem_memread|mem_memwrite) & !dmem_ready.
REQ-005 SHALL prioritise mw > tk > hz when simultaneous.
REQ-006 SHALL, when none active in RUN: all *_we=1, all flush/bubble=0, pc_sel_branch=0; stay RUN.
REQ-007 SHALL, on mw (any state): all *_we=0, memwb_bubble=1, other flushes 0; next state MEMWAIT.
REQ-008 SHALL, in MEMWAIT with dmem_ready=1: behave as RUN for that cycle (all *_we=1), then evaluate tk/hz normally; next state per REQ-009/010 or RUN.
REQ-009 SHALL, on tk (no mw): pc_sel_branch=1, pc_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; next state FLUSH.
REQ-010 SHALL, on hz (no mw, no tk) in RUN: pc_we=0, ifid_we=0, idex_bubble=1; next state LDUSE.
REQ-011 SHALL ignore hz in FLUSH and LDUSE (instruction in EX is bubble or already separated); both states return to RUN after one cycle unless mw/tk.
REQ-012 SHALL combinationally derive outputs from state and inputs; state updates on rising clk only.
REQ-013 SHALL count consecutive MEMWAIT cycles in 8-bit counter, clear on leaving MEMWAIT; when count reaches MEM_TIMEOUT, set mem_err=1 and force RUN next cycle.
REQ-014 SHALL hold mem_err until reset.
REQ-015 SHALL treat ex_rd=0 as never hazardous.

Reset
REQ-016 SHALL, while rst_n=0: state=RUN, mem_err=0, wait counter=0, stall_cnt=0, all *_we=0, ifid_flush=idex_bubble=exmem_flush=memwb_bubble=1, pc_sel_branch=0.
REQ-017 SHALL abort any stall/MEMWAIT immediately on rst_n assertion; first edge after release runs in RUN.

Configuration
REQ-018 SHALL compile stall_cnt logic only with PIPE_STALL_CNT_EN defined: increments (saturating at 16'hFFFF) each cycle pc_we=0 outside reset.
REQ-019 SHALL, without PIPE_STALL_CNT_EN, tie stall_cnt to 0 with no counter flops.

Verification
REQ-020 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1, state=1, then RUN with all we=1.
REQ-021 Branch+hazard same cycle: tk=1, hz=1 -> pc_sel_branch=1, three flushes=1, no stall; next cycle state=2 with hz ignored.
REQ-022 Memory wait: mem_memread=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles all we=0, memwb_bubble=1, state=3; 4th cycle all we=1.
REQ-023 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after 4 MEMWAIT cycles, state returns RUN, mem_err sticky until rst_n=0.
REQ-024 Reset mid-MEMWAIT: rst_n low during state=3 -> state=0, flushes=1, we=0 asynchronously; stall_cnt=0.
REQ-025 With PIPE_STALL_CNT_EN: scenario REQ-022 -> stall_cnt=3; without macro -> stall_cnt=0.
